// File: rtl/reg_wb_buffer.sv
// Register write-back buffer: in-order FIFO merging ALU and load results onto the
// register file's single write port, with youngest-match forwarding for two readers.
module reg_wb_buffer #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     alu_valid,
    input  logic [4:0]               alu_rd,
    input  logic [XLEN-1:0]          alu_data,
    output logic                     alu_ready,
    input  logic                     mem_valid,
    input  logic [4:0]               mem_rd,
    input  logic [XLEN-1:0]          mem_data,
    output logic                     mem_ready,
    output logic [4:0]               a3,
    output logic                     we3,
    output logic [XLEN-1:0]          wd,
    input  logic [4:0]               ra1,
    output logic                     fwd1_hit,
    output logic [XLEN-1:0]          fwd1_data,
    input  logic [4:0]               ra2,
    output logic                     fwd2_hit,
    output logic [XLEN-1:0]          fwd2_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [4:0]      rd_q   [DEPTH];
    logic [4:0]      rd_d   [DEPTH];
    logic [XLEN-1:0] data_q [DEPTH];
    logic [XLEN-1:0] data_d [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;

    logic            full_w, empty_w;
    logic            alu_fire, mem_fire, enq, deq;
    logic [4:0]      in_rd;
    logic [XLEN-1:0] in_data;
    logic [AW-1:0]   idx;

    always_comb begin
        full_w    = (count_q == CW'(DEPTH));
        empty_w   = (count_q == '0);
        alu_ready = !full_w;
        mem_ready = !full_w && !alu_valid;
        alu_fire  = alu_valid && alu_ready;
        mem_fire  = mem_valid && mem_ready;
        in_rd     = alu_fire ? alu_rd   : mem_rd;
        in_data   = alu_fire ? alu_data : mem_data;
        // x0 writes complete the handshake but never occupy a slot
        enq       = (alu_fire || mem_fire) && (in_rd != '0);
        deq       = !empty_w;

        we3 = deq;
        a3  = empty_w ? '0 : rd_q[rd_ptr_q];
        wd  = empty_w ? '0 : data_q[rd_ptr_q];

        rd_d     = rd_q;
        data_d   = data_q;
        valid_d  = valid_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (deq) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = rd_ptr_q + AW'(1);
        end
        if (enq) begin
            rd_d[wr_ptr_q]    = in_rd;
            data_d[wr_ptr_q]  = in_data;
            valid_d[wr_ptr_q] = 1'b1;
            wr_ptr_d          = wr_ptr_q + AW'(1);
        end
        case ({enq, deq})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Walk oldest to youngest so the last match left standing is the youngest
    always_comb begin
        fwd1_hit  = 1'b0;
        fwd1_data = '0;
        fwd2_hit  = 1'b0;
        fwd2_data = '0;
        idx       = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = rd_ptr_q + AW'(i);
            if (valid_q[idx] && (ra1 != '0) && (rd_q[idx] == ra1)) begin
                fwd1_hit  = 1'b1;
                fwd1_data = data_q[idx];
            end
            if (valid_q[idx] && (ra2 != '0) && (rd_q[idx] == ra2)) begin
                fwd2_hit  = 1'b1;
                fwd2_data = data_q[idx];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                rd_q[i]   <= '0;
                data_q[i] <= '0;
            end
            valid_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_q     <= rd_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count = count_q;
    assign full  = full_w;
    assign empty = empty_w;

endmodule
